// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the conv datapath, its sequencer and benches.
//   N      kernel edge; PHASES = 3*N phases per output pixel
//   IMG_W  output image edge; PAD_W = padded image edge
//   FLG_W / CRD_W / ADR_W  phase, coordinate and window-address bus widths
package conv_pkg;

  localparam int unsigned N      = 3;
  localparam int unsigned IMG_W  = 256;
  localparam int unsigned PAD_W  = IMG_W + N - 1;
  localparam int unsigned FLG_W  = 7;
  localparam int unsigned CRD_W  = 8;
  localparam int unsigned ADR_W  = 17;
  localparam int unsigned PHASES = 3 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_e;

  // Padded image edge for an arbitrary kernel / image size.
  function automatic int unsigned pad_w(input int unsigned n, input int unsigned img_w);
    return img_w + n - 1;
  endfunction

endpackage

// File: rtl/conv_seq_if.sv
// Host <-> sequencer bundle.
//   master: host side, drives start/stall, observes phase stream and status
//   slave : sequencer side
//   start, stall                     host controls
//   flg, row, col, win_addr          phase and window coordinates for conv
//   pix_last, busy, done             pixel / frame status
interface conv_seq_if #(
  parameter int unsigned FLG_W = conv_pkg::FLG_W,
  parameter int unsigned CRD_W = conv_pkg::CRD_W,
  parameter int unsigned ADR_W = conv_pkg::ADR_W
);

  logic             start;
  logic             stall;
  logic [FLG_W-1:0] flg;
  logic [CRD_W-1:0] row;
  logic [CRD_W-1:0] col;
  logic [ADR_W-1:0] win_addr;
  logic             pix_last;
  logic             busy;
  logic             done;

  modport master (
    output start, stall,
    input  flg, row, col, win_addr, pix_last, busy, done
  );

  modport slave (
    input  start, stall,
    output flg, row, col, win_addr, pix_last, busy, done
  );

endinterface

// File: rtl/conv_phase_ctr.sv
// Modulo-PHASES counter with synchronous clear and enable.
//   clk, rst_n  clock, async active-low reset
//   clr         force count to 0 (priority over en)
//   en          advance one phase
//   cnt         current phase, 0..PHASES-1
//   wrap_c      count sits on its last phase (combinational)
module conv_phase_ctr #(
  parameter int unsigned PHASES = conv_pkg::PHASES,
  parameter int unsigned W      = conv_pkg::FLG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(PHASES - 1);

  assign wrap_c = (cnt == LAST);

  // Phase register: wraps to 0 after LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/conv_seq.sv
// Self-running phase / window sequencer feeding conv. Walks IMG_W x IMG_W output
// pixels in raster order, 3*N phases each, and tracks the padded-image window base.
//   clk, rst_n  clock, async active-low reset
//   bus         conv_seq_if.slave: start/stall in; flg, row, col, win_addr,
//               pix_last, busy, done out
module conv_seq #(
  parameter int unsigned N     = conv_pkg::N,
  parameter int unsigned IMG_W = conv_pkg::IMG_W,
  parameter int unsigned FLG_W = conv_pkg::FLG_W,
  parameter int unsigned CRD_W = conv_pkg::CRD_W,
  parameter int unsigned ADR_W = conv_pkg::ADR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  conv_seq_if.slave  bus
);

  import conv_pkg::*;

  localparam int unsigned     PHASES   = 3 * N;
  localparam int unsigned     PADW     = pad_w(N, IMG_W);
  localparam logic [CRD_W-1:0] CRD_LAST = CRD_W'(IMG_W - 1);

  // Reject parameter sets whose buses cannot hold their ranges.
  if ((64'(PHASES) > (64'd1 << FLG_W) - 64'd1) ||
      (64'(IMG_W)  > (64'd1 << CRD_W)) ||
      (64'(PADW) * 64'(PADW) - 64'd1 > (64'd1 << ADR_W) - 64'd1)) begin : g_bad_widths
    $error("conv_seq: bus widths too narrow for N/IMG_W");
  end

  seq_state_e       state;
  logic [CRD_W-1:0] row_q;
  logic [CRD_W-1:0] col_q;
  logic [ADR_W-1:0] addr_q;
  logic             busy_q;
  logic             done_q;
  logic [FLG_W-1:0] flg;
  logic             wrap_c;
  logic             adv_c;
  logic             clr_c;
  logic             last_pix_c;

  assign adv_c      = (state == RUN) && !bus.stall;
  assign clr_c      = (state != RUN);
  assign last_pix_c = (row_q == CRD_LAST) && (col_q == CRD_LAST);

  conv_phase_ctr #(
    .PHASES (PHASES),
    .W      (FLG_W)
  ) u_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_c),
    .en     (adv_c),
    .cnt    (flg),
    .wrap_c (wrap_c)
  );

  // FSM, pixel counters and incremental window address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (adv_c && wrap_c) begin
            if (last_pix_c) begin
              state  <= FIN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              row_q  <= '0;
              col_q  <= '0;
              addr_q <= '0;
            end else if (col_q == CRD_LAST) begin
              // Row wrap skips the N-1 padding columns: +1 then +(N-1).
              col_q  <= '0;
              row_q  <= row_q + CRD_W'(1);
              addr_q <= addr_q + ADR_W'(N);
            end else begin
              col_q  <= col_q + CRD_W'(1);
              addr_q <= addr_q + ADR_W'(1);
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.flg      = flg;
  assign bus.row      = row_q;
  assign bus.col      = col_q;
  assign bus.win_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  // Qualified by the live stall so a frozen last phase is not reported twice.
  assign bus.pix_last = busy_q && wrap_c && !bus.stall;

endmodule

// File: tb/tb_conv_seq.sv
// Bench for conv_seq at N=3, IMG_W=4: constant vector table for the opening cycles,
// hand sequences for reset abort / full frame / stall / spurious start, then random
// start and stall checked against a frame-position model.
module tb_conv_seq;

  localparam int T_IMG   = 4;
  localparam int T_PAD   = 6;
  localparam int T_PH    = 9;
  localparam int T_TOTAL = T_IMG * T_IMG * T_PH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_seq_if #(.FLG_W(7), .CRD_W(8), .ADR_W(17)) bus ();

  conv_seq #(.N(3), .IMG_W(T_IMG), .FLG_W(7), .CRD_W(8), .ADR_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running, 2 done cycle; pos = non-stalled run cycles so far.
  int m_mode = 0;
  int m_pos = 0;
  int busy_cnt, pl_cnt, done_cnt;
  logic [16:0] addr_log[$];

  task automatic clear_tally();
    busy_cnt = 0; pl_cnt = 0; done_cnt = 0;
    addr_log.delete();
  endtask

  task automatic step(input logic st, input logic sl);
    int pix;
    @(negedge clk);
    bus.start = st;
    bus.stall = sl;
    #1;
    pix = m_pos / T_PH;
    chk("busy", 32'(bus.busy), 32'(m_mode == 1));
    chk("done", 32'(bus.done), 32'(m_mode == 2));
    chk("pix_last", 32'(bus.pix_last), 32'(m_mode == 1 && (m_pos % T_PH) == T_PH - 1 && !sl));
    if (m_mode == 1) begin
      chk("flg", 32'(bus.flg), 32'(m_pos % T_PH));
      chk("row", 32'(bus.row), 32'(pix / T_IMG));
      chk("col", 32'(bus.col), 32'(pix % T_IMG));
      chk("win_addr", 32'(bus.win_addr), 32'((pix / T_IMG) * T_PAD + pix % T_IMG));
    end else if (m_mode == 0) begin
      chk("idle_flg", 32'(bus.flg), 32'd0);
      chk("idle_row", 32'(bus.row), 32'd0);
      chk("idle_col", 32'(bus.col), 32'd0);
      chk("idle_addr", 32'(bus.win_addr), 32'd0);
    end
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.pix_last) begin
      pl_cnt++;
      addr_log.push_back(bus.win_addr);
    end
    case (m_mode)
      0: if (st) begin m_mode = 1; m_pos = 0; end
      1: if (!sl) begin
           if (m_pos == T_TOTAL - 1) m_mode = 2;
           else m_pos++;
         end
      default: m_mode = 0;
    endcase
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flg"}, 32'(bus.flg), 32'd0);
    chk({tag, "_row"}, 32'(bus.row), 32'd0);
    chk({tag, "_col"}, 32'(bus.col), 32'd0);
    chk({tag, "_addr"}, 32'(bus.win_addr), 32'd0);
    chk({tag, "_pix_last"}, 32'(bus.pix_last), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  typedef struct {
    logic        start;
    logic        stall;
    logic        busy;
    logic [31:0] flg;
    logic [31:0] col;
    logic [31:0] addr;
    logic        pl;
    logic        done;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sl, input logic bz,
                              input logic [31:0] f, input logic [31:0] c,
                              input logic [31:0] a, input logic pl, input logic dn);
    vec_t v;
    v.start = st; v.stall = sl; v.busy = bz; v.flg = f;
    v.col = c; v.addr = a; v.pl = pl; v.done = dn;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected outputs are those visible in the cycle the inputs are applied.
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 3, 0, 0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 4, 0, 0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 5, 0, 0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 6, 0, 0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 7, 0, 0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 8, 0, 0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 8, 0, 0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 0, 1, 1, 1'b0, 1'b0);

    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.start = tbl[i].start;
      bus.stall = tbl[i].stall;
      #1;
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_flg", i), 32'(bus.flg), tbl[i].flg);
      chk($sformatf("tbl%0d_row", i), 32'(bus.row), 32'd0);
      chk($sformatf("tbl%0d_col", i), 32'(bus.col), tbl[i].col);
      chk($sformatf("tbl%0d_addr", i), 32'(bus.win_addr), tbl[i].addr);
      chk($sformatf("tbl%0d_pix_last", i), 32'(bus.pix_last), 32'(tbl[i].pl));
      chk($sformatf("tbl%0d_done", i), 32'(bus.done), 32'(tbl[i].done));
    end

    // Reset mid-frame at flg=5: outputs clear immediately, no done afterwards.
    for (int i = 0; i < 20 && bus.flg != 7'd5; i++) @(negedge clk);
    chk("abort_reach_flg5", 32'(bus.flg), 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 0;
    m_pos = 0;
    clear_tally();
    repeat (5) step(1'b0, 1'b0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Full frame, no stalls.
    clear_tally();
    step(1'b1, 1'b0);
    repeat (T_TOTAL + 20) step(1'b0, 1'b0);
    chk("frame_busy_cycles", 32'(busy_cnt), 32'(T_TOTAL));
    chk("frame_pix_last", 32'(pl_cnt), 32'd16);
    chk("frame_done", 32'(done_cnt), 32'd1);
    chk("addr_log_len", 32'(addr_log.size()), 32'd16);
    for (int i = 0; i < addr_log.size() && i < 16; i++)
      chk($sformatf("addr_walk%0d", i), 32'(addr_log[i]), 32'((i / T_IMG) * T_PAD + i % T_IMG));
    if (addr_log.size() > 0) chk("addr_last", 32'(addr_log[addr_log.size() - 1]), 32'd21);

    // Five-cycle stall on flg=8, col=3 of row 0; then resumes at row 1, col 0.
    clear_tally();
    step(1'b1, 1'b0);
    begin
      int rem = 5;
      for (int i = 0; i < T_TOTAL + 30; i++) begin
        logic s;
        s = (m_mode == 1 && m_pos == 3 * T_PH + 8 && rem > 0);
        if (s) rem--;
        step(1'b0, s);
      end
    end
    chk("stall_busy_cycles", 32'(busy_cnt), 32'(T_TOTAL + 5));
    chk("stall_pix_last", 32'(pl_cnt), 32'd16);
    chk("stall_done", 32'(done_cnt), 32'd1);

    // Spurious start at cycle 50 of the frame.
    clear_tally();
    step(1'b1, 1'b0);
    for (int i = 1; i < T_TOTAL + 20; i++) step(i == 50, 1'b0);
    chk("spur_busy_cycles", 32'(busy_cnt), 32'(T_TOTAL));
    chk("spur_done", 32'(done_cnt), 32'd1);

    // Random start/stall traffic.
    for (int i = 0; i < 700; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
